// File: rtl/fault_latch_array.sv
// rtl/fault_latch_array.sv - N-channel fault synchroniser, debouncer and latch with first-fault capture and event count
module fault_latch_array #(
    parameter int              N_CH       = 12,
    parameter int              DEB_W      = 14,
    parameter logic [N_CH-1:0] LATCH_MASK = {N_CH{1'b1}},
    parameter int              FF_W       = $clog2(N_CH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             time_1us,
    input  logic [N_CH-1:0]  fault_in,
    input  logic [N_CH-1:0]  ch_enable,
    input  logic [DEB_W-1:0] deb_time,
    input  logic             reset_unit,
    output logic [N_CH-1:0]  fault_vec,
    output logic             fault_any,
    output logic [FF_W-1:0]  first_fault,
    output logic             first_valid,
    output logic [7:0]       fault_count
);

    localparam int PC_W = $clog2(N_CH + 1);

    logic [N_CH-1:0]  sync1;
    logic [N_CH-1:0]  sync2;
    logic [DEB_W-1:0] cnt [N_CH];
    logic [DEB_W-1:0] thr;
    logic [N_CH-1:0]  qual;
    logic [N_CH-1:0]  vec_next;
    logic [N_CH-1:0]  rise;
    logic [PC_W-1:0]  rise_cnt;
    logic [FF_W-1:0]  first_idx;
    logic [8:0]       count_sum;
    logic [7:0]       count_next;

    assign thr       = (deb_time == '0) ? DEB_W'(1) : deb_time;
    assign fault_any = |fault_vec;

    // Qualification is gated by the synced input so a self-clearing channel
    // drops on the clock right after the input falls, not after the counter clears.
    always_comb begin
        qual     = '0;
        vec_next = '0;
        for (int i = 0; i < N_CH; i++) begin
            qual[i] = sync2[i] && (cnt[i] >= thr);
            if (reset_unit || !ch_enable[i])
                vec_next[i] = 1'b0;
            else if (LATCH_MASK[i])
                vec_next[i] = fault_vec[i] | qual[i];
            else
                vec_next[i] = qual[i];
        end
    end

    assign rise = vec_next & ~fault_vec;

    always_comb begin
        rise_cnt  = '0;
        first_idx = '0;
        for (int i = 0; i < N_CH; i++)
            rise_cnt = rise_cnt + PC_W'(rise[i]);
        for (int i = N_CH - 1; i >= 0; i--)
            if (rise[i]) first_idx = FF_W'(i);
    end

    assign count_sum  = {1'b0, fault_count} + 9'(rise_cnt);
    assign count_next = (count_sum > 9'd255) ? 8'hFF : count_sum[7:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1       <= '0;
            sync2       <= '0;
            fault_vec   <= '0;
            first_fault <= '0;
            first_valid <= 1'b0;
            fault_count <= '0;
            for (int i = 0; i < N_CH; i++)
                cnt[i] <= '0;
        end else begin
            sync1     <= fault_in;
            sync2     <= sync1;
            fault_vec <= vec_next;
            for (int i = 0; i < N_CH; i++) begin
                if (reset_unit || !sync2[i] || !ch_enable[i])
                    cnt[i] <= '0;
                else if (time_1us && (cnt[i] != '1))
                    cnt[i] <= cnt[i] + DEB_W'(1);
            end
            if (reset_unit) begin
                first_fault <= '0;
                first_valid <= 1'b0;
                fault_count <= '0;
            end else begin
                if (!first_valid && (rise != '0)) begin
                    first_fault <= first_idx;
                    first_valid <= 1'b1;
                end
                fault_count <= count_next;
            end
        end
    end

endmodule

// File: tb/tb_fault_latch_array.sv
// tb/tb_fault_latch_array.sv - self-checking bench for fault_latch_array
module tb_fault_latch_array;

    localparam int N = 12;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         time_1us;
    logic [N-1:0] fault_in;
    logic [N-1:0] ch_enable;
    logic [13:0]  deb_time;
    logic         reset_unit;
    logic [N-1:0] fault_vec;
    logic         fault_any;
    logic [3:0]   first_fault;
    logic         first_valid;
    logic [7:0]   fault_count;

    int pass_cnt = 0;
    int total    = 0;

    fault_latch_array #(
        .N_CH(N), .DEB_W(14), .LATCH_MASK(12'hFFB), .FF_W(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .time_1us(time_1us), .fault_in(fault_in),
        .ch_enable(ch_enable), .deb_time(deb_time), .reset_unit(reset_unit),
        .fault_vec(fault_vec), .fault_any(fault_any), .first_fault(first_fault),
        .first_valid(first_valid), .fault_count(fault_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] bits;
        logic [N-1:0] en;
        int           hold;
        logic [13:0]  deb;
        logic [N-1:0] vec;
        int           first;
        logic         valid;
        int           count;
    } vec_t;

    vec_t tab [8];
    vec_t sb [$];
    vec_t e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_all();
        fault_in  = '0;
        ch_enable = '1;
        repeat (3) step();
        reset_unit = 1'b1;
        step();
        reset_unit = 1'b0;
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        //         bits     en       hold deb  vec      first valid count
        tab[0] = '{12'h008, 12'hFFF, 13, 14'd10, 12'h008, 3,  1'b1, 1};
        tab[1] = '{12'h020, 12'hFFF, 9,  14'd10, 12'h000, 0,  1'b0, 0};
        tab[2] = '{12'h212, 12'hFFF, 12, 14'd10, 12'h212, 1,  1'b1, 3};
        tab[3] = '{12'h004, 12'hFFF, 5,  14'd3,  12'h000, 2,  1'b1, 1};
        tab[4] = '{12'h800, 12'hFFF, 3,  14'd0,  12'h800, 11, 1'b1, 1};
        tab[5] = '{12'hFFF, 12'hFFF, 3,  14'd2,  12'hFFB, 0,  1'b1, 12};
        tab[6] = '{12'h0C0, 12'hFFF, 4,  14'd5,  12'h000, 0,  1'b0, 0};
        tab[7] = '{12'h0C0, 12'hF7F, 8,  14'd5,  12'h040, 6,  1'b1, 1};

        rst_n      = 1'b0;
        time_1us   = 1'b1;
        fault_in   = '0;
        ch_enable  = '1;
        deb_time   = 14'd10;
        reset_unit = 1'b0;
        repeat (3) step();
        check("rst_vec", 32'(fault_vec), 0);
        check("rst_any", 32'(fault_any), 0);
        check("rst_first", 32'(first_fault), 0);
        check("rst_valid", 32'(first_valid), 0);
        check("rst_count", 32'(fault_count), 0);
        rst_n = 1'b1;
        step();

        for (int k = 0; k < 8; k++) begin
            clear_all();
            deb_time  = tab[k].deb;
            ch_enable = tab[k].en;
            fault_in  = tab[k].bits;
            sb.push_back(tab[k]);
            repeat (tab[k].hold) step();
            fault_in = '0;
            repeat (6) step();
            e = sb.pop_front();
            check($sformatf("tab%0d_vec", k), 32'(fault_vec), 32'(e.vec));
            check($sformatf("tab%0d_any", k), 32'(fault_any), 32'(e.vec != 0));
            check($sformatf("tab%0d_first", k), 32'(first_fault), 32'(e.first));
            check($sformatf("tab%0d_valid", k), 32'(first_valid), 32'(e.valid));
            check($sformatf("tab%0d_count", k), 32'(fault_count), 32'(e.count));
        end

        // exact qualification latency: 2 sync + 10 ticks + 1
        clear_all();
        deb_time = 14'd10;
        fault_in = 12'h008;
        repeat (12) step();
        check("lat_pre", 32'(fault_vec), 0);
        step();
        check("lat_vec", 32'(fault_vec), 32'h008);
        check("lat_first", 32'(first_fault), 3);
        check("lat_valid", 32'(first_valid), 1);
        check("lat_count", 32'(fault_count), 1);
        check("lat_any", 32'(fault_any), 1);

        // self-clearing channel 2: rise and fall timing, then re-assertion
        clear_all();
        fault_in = 12'h004;
        repeat (12) step();
        check("sc_pre", 32'(fault_vec), 0);
        step();
        check("sc_rise", 32'(fault_vec), 32'h004);
        repeat (7) step();
        fault_in = '0;
        repeat (2) step();
        check("sc_hold", 32'(fault_vec), 32'h004);
        step();
        check("sc_fall", 32'(fault_vec), 0);
        fault_in = 12'h004;
        repeat (20) step();
        fault_in = '0;
        repeat (4) step();
        check("sc_count2", 32'(fault_count), 2);
        check("sc_first", 32'(first_fault), 2);

        // latched ch7, clear while input high again
        clear_all();
        fault_in = 12'h080;
        repeat (15) step();
        fault_in = '0;
        repeat (5) step();
        check("lt_held", 32'(fault_vec), 32'h080);
        fault_in = 12'h080;
        repeat (14) step();
        reset_unit = 1'b1;
        step();
        reset_unit = 1'b0;
        check("lt_clr_vec", 32'(fault_vec), 0);
        check("lt_clr_valid", 32'(first_valid), 0);
        check("lt_clr_count", 32'(fault_count), 0);
        check("lt_clr_first", 32'(first_fault), 0);
        repeat (10) step();
        check("lt_requal_pre", 32'(fault_vec), 0);
        step();
        check("lt_requal", 32'(fault_vec), 32'h080);
        check("lt_requal_first", 32'(first_fault), 7);

        // simultaneous qualify, then saturation with self-clearing pulses
        clear_all();
        deb_time = 14'd1;
        fault_in = 12'h212;
        repeat (4) step();
        check("sim_vec", 32'(fault_vec), 32'h212);
        check("sim_first", 32'(first_fault), 1);
        check("sim_count", 32'(fault_count), 3);
        for (int i = 0; i < 300; i++) begin
            fault_in = 12'h216;
            repeat (4) step();
            fault_in = 12'h212;
            repeat (4) step();
            if (i == 99) check("sat_mid", 32'(fault_count), 103);
        end
        check("sat_count", 32'(fault_count), 255);
        check("sat_first", 32'(first_fault), 1);

        // async reset mid-latch and mid-count
        clear_all();
        deb_time = 14'd10;
        fault_in = 12'h080;
        repeat (14) step();
        fault_in = 12'h088;
        repeat (5) step();
        #2 rst_n = 1'b0;
        #1;
        check("ar_vec", 32'(fault_vec), 0);
        check("ar_any", 32'(fault_any), 0);
        check("ar_first", 32'(first_fault), 0);
        check("ar_valid", 32'(first_valid), 0);
        check("ar_count", 32'(fault_count), 0);
        step();
        step();
        rst_n = 1'b1;
        repeat (12) step();
        check("ar_requal_pre", 32'(fault_vec), 0);
        step();
        check("ar_requal", 32'(fault_vec), 32'h088);
        check("ar_requal_first", 32'(first_fault), 3);
        check("ar_requal_count", 32'(fault_count), 2);

        // no time_1us strobe: no debounce progress
        clear_all();
        time_1us = 1'b0;
        fault_in = 12'h008;
        repeat (40) step();
        check("notick_vec", 32'(fault_vec), 0);
        time_1us = 1'b1;
        repeat (13) step();
        check("tick_vec", 32'(fault_vec), 32'h008);

        // enable drop on faulted channel keeps first_fault
        ch_enable = 12'hFF7;
        step();
        check("endrop_vec", 32'(fault_vec), 0);
        check("endrop_first", 32'(first_fault), 3);
        check("endrop_valid", 32'(first_valid), 1);
        ch_enable = '1;

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
